// File: rtl/ivt_pkg.sv
// Shared definitions for the interrupt-vector-table read responder:
// FSM encoding, default table/error constants and a width helper.
package ivt_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] DEF_ERR_DATA     = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_RESET_BASE   = 32'h0000_0040;
    localparam logic [31:0] DEF_RESET_STRIDE = 32'h0000_0004;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ivt_table.sv
// Programmable vector table: reset-loaded register array with one write
// port and one combinational read port.
module ivt_table
    import ivt_pkg::*;
#(
    parameter int          DATAW        = 32,
    parameter int          ENTRIES      = 16,
    parameter logic [31:0] RESET_BASE   = DEF_RESET_BASE,
    parameter logic [31:0] RESET_STRIDE = DEF_RESET_STRIDE,
    localparam int         IDXW         = clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_index,
    input  logic [DATAW-1:0] wr_data,
    input  logic [IDXW-1:0]  rd_index,
    output logic [DATAW-1:0] rd_data
);

    logic [DATAW-1:0] mem [ENTRIES];

    // Per-entry index match drops writes to indices with no backing entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++)
                mem[i] <= DATAW'(RESET_BASE + 32'(i) * RESET_STRIDE);
        end else begin
            for (int i = 0; i < ENTRIES; i++)
                if (wr_en && wr_index == IDXW'(i))
                    mem[i] <= wr_data;
        end
    end

    assign rd_data = mem[rd_index];

endmodule

// File: rtl/ivt_read_responder.sv
// Single-outstanding read slave for the emem/sys_r channel: decodes the
// request address into the vector table and answers after LATENCY cycles.
module ivt_read_responder
    import ivt_pkg::*;
#(
    parameter int                ADDRW        = 32,
    parameter int                DATAW        = 32,
    parameter int                ENTRIES      = 16,
    parameter logic [ADDRW-1:0]  IVT_BASE     = '0,
    parameter int                LATENCY      = 2,
    parameter logic [31:0]       RESET_BASE   = DEF_RESET_BASE,
    parameter logic [31:0]       RESET_STRIDE = DEF_RESET_STRIDE,
    parameter logic [DATAW-1:0]  ERR_DATA     = DATAW'(DEF_ERR_DATA)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDRW-1:0]          req_address,
    output logic                      dp_valid,
    input  logic                      dp_ready,
    output logic [DATAW-1:0]          dp_read_data,
    output logic                      dp_error,
    input  logic                      cfg_wr_en,
    input  logic [clog2(ENTRIES)-1:0] cfg_wr_index,
    input  logic [DATAW-1:0]          cfg_wr_data,
    output logic [15:0]               txn_count
);

    localparam int IDXW = clog2(ENTRIES);

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [ADDRW-1:0] off;
    logic             addr_ok;
    logic [DATAW-1:0] tbl_data;

    // Word-aligned and inside the table; off wraps modulo 2^ADDRW.
    assign off     = req_address - IVT_BASE;
    assign addr_ok = (off[1:0] == 2'b00) && (off[ADDRW-1:2+IDXW] == '0);

    ivt_table #(
        .DATAW        (DATAW),
        .ENTRIES      (ENTRIES),
        .RESET_BASE   (RESET_BASE),
        .RESET_STRIDE (RESET_STRIDE)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (cfg_wr_en),
        .wr_index (cfg_wr_index),
        .wr_data  (cfg_wr_data),
        .rd_index (off[2 +: IDXW]),
        .rd_data  (tbl_data)
    );

    // The response is snapshotted at accept, so table writes after that
    // edge (including one in the accept cycle itself) never alter it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            req_ready    <= 1'b0;
            dp_valid     <= 1'b0;
            dp_read_data <= '0;
            dp_error     <= 1'b0;
            txn_count    <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready    <= 1'b0;
                        dp_read_data <= addr_ok ? tbl_data : ERR_DATA;
                        dp_error     <= !addr_ok;
                        cnt          <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state    <= ST_RESP;
                            dp_valid <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state    <= ST_RESP;
                        dp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (dp_ready) begin
                        dp_valid  <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    dp_valid  <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ivt_read_responder.sv
// Bench for ivt_read_responder: vector table of reads plus reset, wrap and
// latency-sweep sequences, with a response scoreboard.
module tb_ivt_read_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_address = '0;
    logic        dp_ready = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [3:0]  cfg_wr_index = '0;
    logic [31:0] cfg_wr_data = '0;

    logic        req_ready, dp_valid, dp_error;
    logic [31:0] dp_read_data;
    logic [15:0] txn_count;
    logic        req_ready_1, dp_valid_1, dp_error_1;
    logic [31:0] dp_read_data_1;
    logic [15:0] txn_count_1;
    logic        req_ready_15, dp_valid_15, dp_error_15;
    logic [31:0] dp_read_data_15;
    logic [15:0] txn_count_15;

    always #5 clk = ~clk;

    ivt_read_responder #(.LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .dp_valid(dp_valid), .dp_ready(dp_ready),
        .dp_read_data(dp_read_data), .dp_error(dp_error), .cfg_wr_en(cfg_wr_en),
        .cfg_wr_index(cfg_wr_index), .cfg_wr_data(cfg_wr_data), .txn_count(txn_count)
    );

    ivt_read_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_1),
        .req_address(req_address), .dp_valid(dp_valid_1), .dp_ready(dp_ready),
        .dp_read_data(dp_read_data_1), .dp_error(dp_error_1), .cfg_wr_en(cfg_wr_en),
        .cfg_wr_index(cfg_wr_index), .cfg_wr_data(cfg_wr_data), .txn_count(txn_count_1)
    );

    ivt_read_responder #(.LATENCY(15)) dut15 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_15),
        .req_address(req_address), .dp_valid(dp_valid_15), .dp_ready(dp_ready),
        .dp_read_data(dp_read_data_15), .dp_error(dp_error_15), .cfg_wr_en(cfg_wr_en),
        .cfg_wr_index(cfg_wr_index), .cfg_wr_data(cfg_wr_data), .txn_count(txn_count_15)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr_en;
        logic [3:0]  wr_idx;
        logic [31:0] wr_data;
        logic        wr_late;
        int          delay;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[10];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard and hold-stability monitor for the LATENCY=2 instance.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_e = 1'b0;
    exp_t        got;

    always @(negedge clk) begin
        if (!reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(dp_valid), 32'd1);
                chk("hold_data", dp_read_data, prev_d);
                chk("hold_err", 32'(dp_error), 32'(prev_e));
            end
            if (dp_valid && dp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got data %h, expected no response", dp_read_data);
                end else begin
                    got = sb.pop_front();
                    chk("resp_data", dp_read_data, got.d);
                    chk("resp_err", 32'(dp_error), 32'(got.e));
                end
            end
            hold_prev = dp_valid && !dp_ready;
            prev_d    = dp_read_data;
            prev_e    = dp_error;
        end
    end

    task automatic do_txn(input vec_t v);
        int n;
        for (int i = 0; i < 50 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_address = v.addr;
        if (!v.wr_late) begin
            cfg_wr_en    = v.wr_en;
            cfg_wr_index = v.wr_idx;
            cfg_wr_data  = v.wr_data;
        end
        sb.push_back({v.exp_data, v.exp_err});
        @(posedge clk); #1;
        req_valid   = 1'b0;
        req_address = $urandom;
        cfg_wr_en   = v.wr_late ? v.wr_en : 1'b0;
        cfg_wr_index = v.wr_idx;
        cfg_wr_data  = v.wr_data;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        n = 1;
        while (!dp_valid && n < 40) begin
            @(posedge clk); #1;
            cfg_wr_en = 1'b0;
            n++;
        end
        cfg_wr_en = 1'b0;
        chk("latency", 32'(n), 32'd2);
        repeat (v.delay) begin
            @(posedge clk); #1;
        end
        chk("req_ready_resp", 32'(req_ready), 32'd0);
        dp_ready = 1'b1;
        @(posedge clk); #1;
        dp_ready = 1'b0;
        exp_cnt  = exp_cnt + 16'd1;
        chk("valid_after_hs", 32'(dp_valid), 32'd0);
        chk("req_ready_after_hs", 32'(req_ready), 32'd1);
        chk("txn_count", 32'(txn_count), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r2, r1, r15;
        vecs[0] = '{32'h08, 0, 4'd0, 32'h0, 0, 0, 32'h48, 0};
        vecs[1] = '{32'h00, 0, 4'd0, 32'h0, 0, 5, 32'h40, 0};
        vecs[2] = '{32'h0C, 1, 4'd3, 32'h1234_5678, 0, 0, 32'h4C, 0};
        vecs[3] = '{32'h0C, 0, 4'd0, 32'h0, 0, 0, 32'h1234_5678, 0};
        vecs[4] = '{32'h40, 0, 4'd0, 32'h0, 0, 0, 32'hDEAD_BEEF, 1};
        vecs[5] = '{32'h06, 0, 4'd0, 32'h0, 0, 2, 32'hDEAD_BEEF, 1};
        vecs[6] = '{32'h3C, 0, 4'd0, 32'h0, 0, 1, 32'h7C, 0};
        vecs[7] = '{32'h10, 1, 4'd4, 32'hAAAA_5555, 1, 3, 32'h50, 0};
        vecs[8] = '{32'h10, 0, 4'd0, 32'h0, 0, 0, 32'hAAAA_5555, 0};
        vecs[9] = '{32'hFFFF_FFFC, 0, 4'd0, 32'h0, 0, 0, 32'hDEAD_BEEF, 1};

        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_dp_valid", 32'(dp_valid), 32'd0);
        chk("rst_data", dp_read_data, 32'd0);
        chk("rst_err", 32'(dp_error), 32'd0);
        chk("rst_txn_count", 32'(txn_count), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        foreach (vecs[i]) do_txn(vecs[i]);

        // Counter wrap: preload to all-ones, one more handshake returns to zero.
        force dut.txn_count = 16'hFFFF;
        #1;
        release dut.txn_count;
        exp_cnt = 16'hFFFF;
        do_txn('{32'h04, 0, 4'd0, 32'h0, 0, 0, 32'h44, 0});
        chk("wrap_zero", 32'(txn_count), 32'd0);

        // Reset in WAIT drops the response and reloads the table.
        cfg_wr_en = 1'b1; cfg_wr_index = 4'd1; cfg_wr_data = 32'hCAFE_0001;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        chk("ready_pre_abort", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_address = 32'h04;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(dp_valid), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_txn_count", 32'(txn_count), 32'd0);
        chk("abort_data", dp_read_data, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_hold_valid", 32'(dp_valid), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_l2", 32'(req_ready), 32'd1);
        chk("ready_l1", 32'(req_ready_1), 32'd1);
        chk("ready_l15", 32'(req_ready_15), 32'd1);

        // Latency sweep across the three instances; dp_ready held high throughout.
        r2 = 0; r1 = 0; r15 = 0;
        dp_ready = 1'b1;
        req_valid = 1'b1; req_address = 32'h04;
        sb.push_back({32'h44, 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (dp_valid && r2 == 0) r2 = n;
            if (dp_valid_1 && r1 == 0) begin
                r1 = n;
                chk("l1_data", dp_read_data_1, 32'h44);
                chk("l1_err", 32'(dp_error_1), 32'd0);
            end
            if (dp_valid_15 && r15 == 0) begin
                r15 = n;
                chk("l15_data", dp_read_data_15, 32'h44);
                chk("l15_err", 32'(dp_error_15), 32'd0);
            end
            @(posedge clk); #1;
        end
        dp_ready = 1'b0;
        chk("lat_l2", 32'(r2), 32'd2);
        chk("lat_l1", 32'(r1), 32'd1);
        chk("lat_l15", 32'(r15), 32'd15);
        chk("sweep_cnt_l2", 32'(txn_count), 32'd1);
        chk("sweep_cnt_l1", 32'(txn_count_1), 32'd1);
        chk("sweep_cnt_l15", 32'(txn_count_15), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
